counter_code_decoder: RTL and testbench



---
 rtl/counter_code_decoder_pkg.sv | 14 +
 rtl/counter_code_resolve.sv | 23 ++
 rtl/counter_code_decoder.sv | 78 +++++++
 tb/tb_counter_code_decoder.sv | 124 ++++++++++++
 4 files changed

// File: rtl/counter_code_decoder_pkg.sv
// counter_code_decoder_pkg: shared state type, code bit indices and hex 7-seg patterns.
package counter_code_decoder_pkg;
  typedef enum logic {ST_SEARCH, ST_LOCKED} state_t;
  localparam int C3 = 3;
  localparam int C2 = 2;
  localparam int C1 = 1;
  localparam int C0 = 0;
  localparam logic [15:0][6:0] SEG_LUT = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };
endpackage

// File: rtl/counter_code_resolve.sv
// counter_code_resolve: decodes a code word to a count, using prev+1 to break the s0==s2 ambiguity.
module counter_code_resolve
  import counter_code_decoder_pkg::*;
(
  input  logic [3:0] code_in,
  input  logic [3:0] prev,
  input  logic       have_prev,
  output logic [3:0] s,
  output logic       illegal,
  output logic       in_seq
);
  logic [3:0] b, alt, nxt;
  assign b = {code_in[C0], 1'b0, code_in[C2], 1'b0};
  assign alt = b | 4'b0101;
  assign nxt = prev + 4'd1;
  assign illegal = code_in[C3] & code_in[C1];
  always_comb begin
    s = code_in[C3] ? (b | 4'b0001) :
        code_in[C1] ? (b | 4'b0100) :
        (have_prev && alt == nxt) ? alt : b;
    in_seq = have_prev && s == nxt;
  end
endmodule

// File: rtl/counter_code_decoder.sv
// counter_code_decoder: sequence-aware decoder for the 4-bit counter code with lock FSM and error counter.
// Define CCD_SEVEN_SEG_EN to add the registered active-low hex display output seg_n.
module counter_code_decoder
  import counter_code_decoder_pkg::*;
#(
  parameter int LOCK_N = 2,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       code_in,
  input  logic             code_valid,
  output logic [3:0]       count_out,
  output logic             count_valid,
  output logic             illegal_err,
  output logic             seq_err,
  output logic             locked,
  output logic [ERR_W-1:0] err_cnt
`ifdef CCD_SEVEN_SEG_EN
  ,
  output logic [6:0]       seg_n
`endif
);
  logic [3:0] prev, s, run;
  logic have_prev, illegal, in_seq, seq_bad;
  state_t state;
  counter_code_resolve u_resolve (
    .code_in  (code_in),
    .prev     (prev),
    .have_prev(have_prev),
    .s        (s),
    .illegal  (illegal),
    .in_seq   (in_seq)
  );
  assign seq_bad = !illegal && state == ST_LOCKED && !in_seq;
  assign locked = state == ST_LOCKED;
  always_ff @(posedge clk) begin
    if (reset) begin
      count_out   <= '0;
      count_valid <= 1'b0;
      illegal_err <= 1'b0;
      seq_err     <= 1'b0;
      err_cnt     <= '0;
      state       <= ST_SEARCH;
      run         <= '0;
      prev        <= '0;
      have_prev   <= 1'b0;
`ifdef CCD_SEVEN_SEG_EN
      seg_n       <= 7'b1000000;
`endif
    end else begin
      count_valid <= code_valid && !illegal;
      illegal_err <= code_valid && illegal;
      seq_err     <= code_valid && seq_bad;
      if (code_valid) begin
        if (illegal) begin
          state <= ST_SEARCH;
          run   <= '0;
        end else begin
          count_out <= s;
          prev      <= s;
          have_prev <= 1'b1;
`ifdef CCD_SEVEN_SEG_EN
          seg_n     <= SEG_LUT[s];
`endif
          if (!in_seq) begin
            state <= ST_SEARCH;
            run   <= '0;
          end else if (state == ST_SEARCH) begin
            run <= run + 4'd1;
            if (run + 4'd1 == 4'(LOCK_N)) state <= ST_LOCKED;
          end
        end
        if ((illegal || seq_bad) && err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_counter_code_decoder.sv
// tb_counter_code_decoder: directed self-checking bench for counter_code_decoder.
module tb_counter_code_decoder;
  logic clk = 1'b0, reset = 1'b0, code_valid = 1'b0;
  logic [3:0] code_in = '0;
  logic [3:0] count_out, count_out2;
  logic count_valid, illegal_err, seq_err, locked;
  logic count_valid2, illegal_err2, seq_err2, locked2;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt2;
`ifdef CCD_SEVEN_SEG_EN
  logic [6:0] seg_n, seg_n2;
`endif
  int errs = 0, checks = 0;

  always #5 clk = ~clk;

  counter_code_decoder #(.LOCK_N(2), .ERR_W(8)) dut (
    .clk(clk), .reset(reset), .code_in(code_in), .code_valid(code_valid),
    .count_out(count_out), .count_valid(count_valid), .illegal_err(illegal_err),
    .seq_err(seq_err), .locked(locked), .err_cnt(err_cnt)
`ifdef CCD_SEVEN_SEG_EN
    , .seg_n(seg_n)
`endif
  );

  counter_code_decoder #(.LOCK_N(2), .ERR_W(2)) dut2 (
    .clk(clk), .reset(reset), .code_in(code_in), .code_valid(code_valid),
    .count_out(count_out2), .count_valid(count_valid2), .illegal_err(illegal_err2),
    .seq_err(seq_err2), .locked(locked2), .err_cnt(err_cnt2)
`ifdef CCD_SEVEN_SEG_EN
    , .seg_n(seg_n2)
`endif
  );

  function automatic logic [3:0] enc(input logic [3:0] v);
    return {v[0] & ~v[2], v[1], ~v[0] & v[2], v[3]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic word(input logic [3:0] c);
    @(negedge clk);
    code_in = c;
    code_valid = 1'b1;
    @(posedge clk);
    #1 code_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic st(input string tag, input logic [3:0] cnt, input logic cv, input logic ill,
                    input logic se, input logic lk, input logic [7:0] ec);
    chk({tag, ".count"}, count_out, cnt);
    chk({tag, ".valid"}, count_valid, cv);
    chk({tag, ".illegal"}, illegal_err, ill);
    chk({tag, ".seq"}, seq_err, se);
    chk({tag, ".locked"}, locked, lk);
    chk({tag, ".errcnt"}, err_cnt, ec);
  endtask

  initial begin
    do_reset();
    st("reset", 4'd0, 0, 0, 0, 0, 8'd0);
`ifdef CCD_SEVEN_SEG_EN
    chk("seg_reset", seg_n, 7'b1000000);
`endif
    word(4'b1100); st("w3", 4'd3, 1, 0, 0, 0, 8'd0);
`ifdef CCD_SEVEN_SEG_EN
    chk("seg_3", seg_n, 7'b0110000);
`endif
    word(4'b0010); st("w4", 4'd4, 1, 0, 0, 0, 8'd0);
    word(4'b0000); st("w5_amb", 4'd5, 1, 0, 0, 1, 8'd0);
    for (int v = 6; v < 16; v++) word(enc(4'(v)));
    st("at15", 4'd15, 1, 0, 0, 1, 8'd0);
    word(4'b0000); st("wrap0", 4'd0, 1, 0, 0, 1, 8'd0);
    for (int v = 1; v < 5; v++) word(enc(4'(v)));
    st("at4", 4'd4, 1, 0, 0, 1, 8'd0);
    word(4'b1010); st("illegal", 4'd4, 0, 1, 0, 0, 8'd1);
    word(enc(4'd2)); st("re2", 4'd2, 1, 0, 0, 0, 8'd1);
    word(enc(4'd3)); st("re3", 4'd3, 1, 0, 0, 0, 8'd1);
    word(enc(4'd4)); st("re4", 4'd4, 1, 0, 0, 1, 8'd1);
    word(4'b1000); st("seqerr", 4'd1, 1, 0, 1, 0, 8'd2);
    word(4'b0000); st("amb_nomatch", 4'd0, 1, 0, 0, 0, 8'd2);
    do_reset();
    word(4'b0000); st("first_amb", 4'd0, 1, 0, 0, 0, 8'd0);
    word(4'b0100); st("val2", 4'd2, 1, 0, 0, 0, 8'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 st("idle", 4'd2, 0, 0, 0, 0, 8'd0);
    end
    for (int i = 0; i < 5; i++) begin
      word(4'b1111);
      chk("sat_ill", illegal_err2, 1'b1);
      chk("sat_cnt", err_cnt2, (i < 3) ? i + 1 : 3);
      chk("wide_cnt", err_cnt, i + 1);
    end
    word(4'b1100); st("pre_rst", 4'd3, 1, 0, 0, 0, 8'd5);
    @(negedge clk);
    reset = 1'b1;
    code_in = 4'b0010;
    code_valid = 1'b1;
    @(posedge clk);
    #1 st("rst_vs_valid", 4'd0, 0, 0, 0, 0, 8'd0);
    chk("rst_vs_valid.cnt2", err_cnt2, 2'd0);
    @(negedge clk);
    reset = 1'b0;
    code_valid = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
